// File: rtl/pdm_run_histogram.sv
// -----------------------------------------------------------------------------
// pdm_run_histogram
//
// Builds a histogram of PDM microphone "ones" run lengths over a fixed capture
// window. Every accepted 0 sample closes the current run, and the bin indexed
// by the run length is incremented. Runs of BIN_COUNT or more ones count in
// overflow_count instead of a bin. A run still open at the end of the window
// is dropped.
//
// Sequencing: IDLE --start--> CLEAR --(BIN_COUNT cycles)--> CAPTURE
//             --(WINDOW_LEN accepted samples)--> DONE --start--> CLEAR ...
//
// Handshake: a sample is accepted on a rising edge in CAPTURE when
// sample_valid=1 and sample_en=1. There is no backpressure, so one sample per
// cycle is sustained. sample_en=0 holds the run without breaking it.
//
// Ports:
//   clk            in   system clock, rising edge
//   rst            in   synchronous active-high reset (aborts CLEAR/CAPTURE)
//   start          in   pulse; begins clear-then-capture from IDLE or DONE
//   sample_en      in   capture enable switch
//   sample_valid   in   one-cycle strobe qualifying mic_sample
//   mic_sample     in   PDM bit
//   rd_addr        in   bin to read; addresses >= BIN_COUNT read as 0
//   rd_data        out  registered bin value, one cycle after rd_addr
//   overflow_count out  runs of length >= BIN_COUNT, saturating
//   busy           out  high in CLEAR and CAPTURE
//   done           out  high in DONE; histogram frozen
// -----------------------------------------------------------------------------
module pdm_run_histogram #(
    parameter int BIN_COUNT  = 50,
    parameter int COUNT_W    = 20,
    parameter int ADDR_W     = 6,
    parameter int WINDOW_LEN = 1000000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               sample_en,
    input  logic               sample_valid,
    input  logic               mic_sample,
    input  logic [ADDR_W-1:0]  rd_addr,
    output logic [COUNT_W-1:0] rd_data,
    output logic [COUNT_W-1:0] overflow_count,
    output logic               busy,
    output logic               done
);

    // run_len must be able to hold BIN_COUNT itself (the saturated value).
    localparam int RL_W = $clog2(BIN_COUNT + 1);
    // The sample counter only ever holds 0..WINDOW_LEN-1: the last accepted
    // sample moves the FSM to DONE instead of bumping the counter.
    localparam int SC_W = (WINDOW_LEN > 1) ? $clog2(WINDOW_LEN) : 1;

    localparam logic [RL_W-1:0]    RL_SAT    = RL_W'(BIN_COUNT);
    localparam logic [SC_W-1:0]    SC_LAST   = SC_W'(WINDOW_LEN - 1);
    localparam logic [ADDR_W-1:0]  ADDR_LAST = ADDR_W'(BIN_COUNT - 1);
    localparam logic [COUNT_W-1:0] CNT_MAX   = {COUNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CLEAR   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  clr_addr_q, clr_addr_d;
    logic [RL_W-1:0]    run_len_q, run_len_d;
    logic [SC_W-1:0]    sample_cnt_q, sample_cnt_d;
    logic [COUNT_W-1:0] overflow_q, overflow_d;
    logic [COUNT_W-1:0] rd_data_q, rd_data_d;
    logic [COUNT_W-1:0] bin_q [BIN_COUNT];
    logic [COUNT_W-1:0] bin_d [BIN_COUNT];
    logic               accept;

    // -------------------------------------------------------------------------
    // Next-state and datapath update
    // -------------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        clr_addr_d   = clr_addr_q;
        run_len_d    = run_len_q;
        sample_cnt_d = sample_cnt_q;
        overflow_d   = overflow_q;
        bin_d        = bin_q;
        accept       = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d      = ST_CLEAR;
                    clr_addr_d   = '0;
                    run_len_d    = '0;
                    sample_cnt_d = '0;
                    overflow_d   = '0;
                end
            end

            ST_CLEAR: begin
                // One bin per cycle; the last address hands over to CAPTURE,
                // so CLEAR lasts exactly BIN_COUNT cycles.
                for (int i = 0; i < BIN_COUNT; i++) begin
                    if (clr_addr_q == ADDR_W'(i)) begin
                        bin_d[i] = '0;
                    end
                end
                if (clr_addr_q == ADDR_LAST) begin
                    state_d = ST_CAPTURE;
                end else begin
                    clr_addr_d = clr_addr_q + 1'b1;
                end
            end

            ST_CAPTURE: begin
                accept = sample_valid && sample_en;
                if (accept) begin
                    if (mic_sample) begin
                        if (run_len_q != RL_SAT) begin
                            run_len_d = run_len_q + 1'b1;
                        end
                    end else begin
                        // A zero closes the run: saturated runs go to the
                        // overflow counter, shorter ones to their bin.
                        if (run_len_q == RL_SAT) begin
                            if (overflow_q != CNT_MAX) begin
                                overflow_d = overflow_q + 1'b1;
                            end
                        end else begin
                            for (int i = 0; i < BIN_COUNT; i++) begin
                                if (run_len_q == RL_W'(i) && bin_q[i] != CNT_MAX) begin
                                    bin_d[i] = bin_q[i] + 1'b1;
                                end
                            end
                        end
                        run_len_d = '0;
                    end

                    // The final sample's update lands on the same edge that
                    // enters DONE; any open run is simply left unbinned.
                    if (sample_cnt_q == SC_LAST) begin
                        state_d = ST_DONE;
                    end else begin
                        sample_cnt_d = sample_cnt_q + 1'b1;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Read port: reads the current (pre-update) array, so an address being
    // written on the same edge returns its old value.
    // -------------------------------------------------------------------------
    always_comb begin
        rd_data_d = '0;
        for (int i = 0; i < BIN_COUNT; i++) begin
            if (rd_addr == ADDR_W'(i)) begin
                rd_data_d = bin_q[i];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Control and status registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            clr_addr_q   <= '0;
            run_len_q    <= '0;
            sample_cnt_q <= '0;
            overflow_q   <= '0;
            rd_data_q    <= '0;
        end else begin
            state_q      <= state_d;
            clr_addr_q   <= clr_addr_d;
            run_len_q    <= run_len_d;
            sample_cnt_q <= sample_cnt_d;
            overflow_q   <= overflow_d;
            rd_data_q    <= rd_data_d;
        end
    end

    // Bin storage has no reset; CLEAR establishes its contents.
    always_ff @(posedge clk) begin
        bin_q <= bin_d;
    end

    assign rd_data        = rd_data_q;
    assign overflow_count = overflow_q;
    assign busy           = (state_q == ST_CLEAR) || (state_q == ST_CAPTURE);
    assign done           = (state_q == ST_DONE);

endmodule
